// File: rtl/ysyx_23060191_mem_arbiter_pkg.sv
// Shared types and defaults for the IFU/LSU memory-port arbiter.
// State and owner encodings are visible here so checkers can bind to them.
package ysyx_23060191_mem_arbiter_pkg;

  localparam int CPU_WIDTH   = 32;
  localparam int ADDR_W_DEF  = CPU_WIDTH;
  localparam int DATA_W_DEF  = CPU_WIDTH;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_23060191_mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction in flight,
// with a REQ+WAIT timeout and draining of responses orphaned by that timeout.
module ysyx_23060191_mem_arbiter
  import ysyx_23060191_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  output logic                ifu_rsp_err,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_rdata,
  output logic                lsu_rsp_err,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  input  logic                mem_rsp_err,

  output logic                busy,
  output arb_state_e          dbg_state
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e         state;
  owner_e             owner;
  logic               orphan;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic               wen_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [MASK_W-1:0]  wmask_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic               tmo_hit;

  // Reaching TIMEOUT at this edge: cnt counts REQ+WAIT cycles already spent.
  assign tmo_hit = (cnt >= CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      owner   <= OWN_IFU;
      orphan  <= 1'b0;
      cnt     <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (orphan) begin
            if (mem_rsp_valid) orphan <= 1'b0;
          end else if (lsu_req_valid) begin
            addr_q  <= lsu_req_addr;
            wen_q   <= lsu_req_wen;
            wdata_q <= lsu_req_wdata;
            wmask_q <= lsu_req_wmask;
            owner   <= OWN_LSU;
            cnt     <= '0;
            state   <= ST_REQ;
          end else if (ifu_req_valid) begin
            addr_q  <= ifu_req_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            owner   <= OWN_IFU;
            cnt     <= '0;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_req_ready) begin
            state <= ST_WAIT;
          end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_rsp_valid) begin
            rdata_q <= mem_rsp_data;
            err_q   <= mem_rsp_err;
            state   <= ST_RESP;
          end else if (tmo_hit) begin
            // The slave still owes a response; swallow it later in IDLE.
            rdata_q <= '0;
            err_q   <= 1'b1;
            orphan  <= 1'b1;
            state   <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and only ifu_req_ready looks at an input.
  assign lsu_req_ready = (state == ST_IDLE) && !orphan;
  assign ifu_req_ready = (state == ST_IDLE) && !orphan && !lsu_req_valid;

  assign mem_req_valid = (state == ST_REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign mem_rsp_ready = (state == ST_WAIT) || ((state == ST_IDLE) && orphan);

  assign ifu_rsp_valid = (state == ST_RESP) && (owner == OWN_IFU);
  assign ifu_rsp_data  = rdata_q;
  assign ifu_rsp_err   = err_q;
  assign lsu_rsp_valid = (state == ST_RESP) && (owner == OWN_LSU);
  assign lsu_rsp_rdata = rdata_q;
  assign lsu_rsp_err   = err_q;

  assign busy      = (state != ST_IDLE) || orphan;
  assign dbg_state = state;

endmodule

// File: tb/tb_ysyx_23060191_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: a behavioural memory slave, directed
// scenarios and a randomized back-to-back run checked against latency/data rules.
module tb_ysyx_23060191_mem_arbiter;
  import ysyx_23060191_mem_arbiter_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MASK_W  = 4;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic [DATA_W-1:0] ifu_rsp_data;
  logic              lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic [DATA_W-1:0] lsu_req_wdata, lsu_rsp_rdata;
  logic [MASK_W-1:0] lsu_req_wmask;
  logic              mem_req_valid, mem_req_ready, mem_req_wen;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata, mem_rsp_data;
  logic [MASK_W-1:0] mem_req_wmask;
  logic              mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
  logic              busy;
  arb_state_e        dbg_state;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  // memory slave configuration and state
  int          req_stall = 0;
  int          rsp_stall = 0;
  bit          silent = 0;
  bit          stray = 0;
  bit          use_fixed = 0;
  bit          cfg_err = 0;
  logic [31:0] fixed_data = 32'h0;
  bit          pending = 0;
  int          req_seen = 0;
  int          rsp_wait = 0;
  bit          req_hs, rsp_hs;
  logic [31:0] hs_data;

  ysyx_23060191_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_err(mem_rsp_err), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- memory slave model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic w, input logic [31:0] d);
    return w ? (d ^ {a[15:0], a[31:16]}) : ((a * 32'd2654435761) ^ 32'h0F0F_1234);
  endfunction

  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_err   = 1'b0;
  end

  always begin
    @(negedge clk);
    req_hs  = mem_req_valid && mem_req_ready;
    rsp_hs  = mem_rsp_valid && mem_rsp_ready;
    hs_data = use_fixed ? fixed_data : mem_word(mem_req_addr, mem_req_wen, mem_req_wdata);
    @(posedge clk);
    #1;
    if (rst) begin
      pending = 0; req_seen = 0; rsp_wait = 0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    end else begin
      if (rsp_hs) pending = 0;
      if (req_hs) begin
        pending = 1; rsp_wait = 0; req_seen = 0;
        mem_rsp_data = hs_data; mem_rsp_err = cfg_err;
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (mem_req_valid && !pending) begin
        mem_req_ready = (req_seen >= req_stall);
        req_seen++;
      end else begin
        req_seen = 0;
      end
      if (pending && !silent) begin
        mem_rsp_valid = (rsp_wait >= rsp_stall);
        rsp_wait++;
      end
      if (stray) mem_rsp_valid = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input bit want_ifu, input bit want_lsu, input logic [31:0] i_addr,
                       input logic [31:0] l_addr, input logic l_wen, input logic [31:0] l_wdata,
                       input logic [3:0] l_wmask, output bit got, output bit who, output int acc);
    ifu_req_valid = want_ifu; ifu_req_addr = i_addr;
    lsu_req_valid = want_lsu; lsu_req_addr = l_addr;
    lsu_req_wen = l_wen; lsu_req_wdata = l_wdata; lsu_req_wmask = l_wmask;
    got = 0; who = 0; acc = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      #1;
      if (lsu_req_valid && lsu_req_ready) begin got = 1; who = 1; end
      else if (ifu_req_valid && ifu_req_ready) begin got = 1; who = 0; end
      if (!got) @(negedge clk);
    end
    acc = cyc;
    @(negedge clk);
    if (who) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output bit got, output bit who, output logic [31:0] data,
                          output logic err, output int at, output bit both);
    got = 0; who = 0; data = '0; err = 1'b0; at = 0; both = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (ifu_rsp_valid || lsu_rsp_valid) begin
        got = 1; who = lsu_rsp_valid; both = ifu_rsp_valid && lsu_rsp_valid;
        data = lsu_rsp_valid ? lsu_rsp_rdata : ifu_rsp_data;
        err = lsu_rsp_valid ? lsu_rsp_err : ifu_rsp_err;
        at = cyc;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    ifu_req_valid = 0; ifu_req_addr = '0;
    lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    n_cmp++; if ({ifu_req_ready, lsu_req_ready} !== 2'b11) begin n_err++; $display("FAIL reset_ready: got %b want 11", {ifu_req_ready, lsu_req_ready}); end
    n_cmp++; if ({mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid, busy} !== 5'b0) begin n_err++; $display("FAIL reset_valids: got %b want 00000", {mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid, busy}); end
    lsu_req_valid = 1'b1;
    #1;
    n_cmp++; if (ifu_req_ready !== 1'b0) begin n_err++; $display("FAIL ifu_ready_masked: got %b want 0", ifu_req_ready); end
    lsu_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ifu_fetch();
    bit g, w, both; int acc, at; logic [31:0] d; logic e;
    use_fixed = 1; fixed_data = 32'h0000_0413; req_stall = 0; rsp_stall = 0; cfg_err = 0;
    issue(1, 0, 32'h8000_0000, '0, 0, '0, '0, g, w, acc);
    n_cmp++; if (g !== 1'b1 || w !== 1'b0) begin n_err++; $display("FAIL fetch_grant: got %b%b want 10", g, w); end
    n_cmp++; if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask} !== {1'b1, 32'h8000_0000, 1'b0, 4'h0})
      begin n_err++; $display("FAIL fetch_memreq: got v%b a%h w%b m%h want v1 a80000000 w0 m0", mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fetch_busy: got %b want 1", busy); end
    exp_q.push_back(32'h0000_0413);
    wait_rsp(20, g, w, d, e, at, both);
    n_cmp++; if (g !== 1'b1 || w !== 1'b0 || both !== 1'b0) begin n_err++; $display("FAIL fetch_owner: got g%b lsu%b both%b want g1 lsu0 both0", g, w, both); end
    n_cmp++; if (at - acc !== 3) begin n_err++; $display("FAIL fetch_latency: got %0d want 3", at - acc); end
    n_cmp++; if (d !== exp_q.pop_front() || e !== 1'b0) begin n_err++; $display("FAIL fetch_data: got %h err %b want 00000413 err 0", d, e); end
    @(negedge clk);
    n_cmp++; if ({ifu_rsp_valid, busy, ifu_req_ready} !== 3'b001) begin n_err++; $display("FAIL fetch_after: got %b want 001", {ifu_rsp_valid, busy, ifu_req_ready}); end
    use_fixed = 0;
  endtask

  task automatic test_priority();
    bit g, w, both; int acc, acc2, at; logic [31:0] d, ex; logic e;
    issue(1, 1, 32'h8000_0100, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, g, w, acc);
    n_cmp++; if (g !== 1'b1 || w !== 1'b1) begin n_err++; $display("FAIL prio_grant: got %b%b want 11", g, w); end
    n_cmp++; if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== {32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF})
      begin n_err++; $display("FAIL prio_memreq: got a%h w%b d%h m%h want a80000010 w1 ddeadbeef mf", mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask); end
    n_cmp++; if (ifu_req_ready !== 1'b0) begin n_err++; $display("FAIL prio_ifu_blocked: got %b want 0", ifu_req_ready); end
    exp_q.push_back(mem_word(32'h8000_0010, 1'b1, 32'hDEAD_BEEF));
    wait_rsp(20, g, w, d, e, at, both);
    ex = exp_q.pop_front();
    n_cmp++; if (g !== 1'b1 || w !== 1'b1 || at - acc !== 3 || d !== ex)
      begin n_err++; $display("FAIL prio_lsu_rsp: got g%b lsu%b lat%0d d%h want g1 lsu1 lat3 d%h", g, w, at - acc, d, ex); end
    issue(1, 0, 32'h8000_0100, '0, 0, '0, '0, g, w, acc2);
    n_cmp++; if (g !== 1'b1 || w !== 1'b0 || acc2 - acc !== 4) begin n_err++; $display("FAIL prio_ifu_next: got g%b lsu%b gap%0d want g1 lsu0 gap4", g, w, acc2 - acc); end
    exp_q.push_back(mem_word(32'h8000_0100, 1'b0, 32'h0));
    wait_rsp(20, g, w, d, e, at, both);
    ex = exp_q.pop_front();
    n_cmp++; if (g !== 1'b1 || w !== 1'b0 || d !== ex || e !== 1'b0)
      begin n_err++; $display("FAIL prio_ifu_rsp: got g%b lsu%b d%h e%b want g1 lsu0 d%h e0", g, w, d, e, ex); end
  endtask

  task automatic test_stall_err();
    bit g, w, both; int acc, at; logic [31:0] d, a, ex; logic e;
    a = $urandom; req_stall = 5; rsp_stall = 0; cfg_err = 1;
    issue(0, 1, '0, a, 1'b0, '0, '0, g, w, acc);
    exp_q.push_back(mem_word(a, 1'b0, 32'h0));
    wait_rsp(40, g, w, d, e, at, both);
    ex = exp_q.pop_front();
    n_cmp++; if (g !== 1'b1 || w !== 1'b1 || at - acc !== 8) begin n_err++; $display("FAIL stall_latency: got g%b lsu%b lat%0d want g1 lsu1 lat8", g, w, at - acc); end
    n_cmp++; if (e !== 1'b1 || d !== ex) begin n_err++; $display("FAIL stall_err: got e%b d%h want e1 d%h", e, d, ex); end
    req_stall = 0; cfg_err = 0;
  endtask

  task automatic test_timeout_wait();
    bit g, w, both, seen; int acc, at; logic [31:0] d; logic e;
    silent = 1;
    issue(0, 1, '0, 32'h8000_2000, 1'b1, 32'h1234_5678, 4'h3, g, w, acc);
    wait_rsp(TIMEOUT + 20, g, w, d, e, at, both);
    n_cmp++; if (g !== 1'b1 || w !== 1'b1 || at - acc !== TIMEOUT + 1) begin n_err++; $display("FAIL tmo_latency: got g%b lsu%b lat%0d want g1 lsu1 lat%0d", g, w, at - acc, TIMEOUT + 1); end
    n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL tmo_rsp: got e%b d%h want e1 d00000000", e, d); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({ifu_req_ready, lsu_req_ready, mem_rsp_ready, busy} !== 4'b0011) begin n_err++; $display("FAIL tmo_orphan_hold: got %b want 0011", {ifu_req_ready, lsu_req_ready, mem_rsp_ready, busy}); end
    silent = 0; seen = 0;
    for (int i = 0; i < 10 && busy; i++) begin
      @(negedge clk);
      if (ifu_rsp_valid || lsu_rsp_valid) seen = 1;
    end
    n_cmp++; if (seen !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL tmo_drain: got fwd%b busy%b want fwd0 busy0", seen, busy); end
    n_cmp++; if ({ifu_req_ready, lsu_req_ready, mem_rsp_ready} !== 3'b110) begin n_err++; $display("FAIL tmo_reopen: got %b want 110", {ifu_req_ready, lsu_req_ready, mem_rsp_ready}); end
    issue(1, 0, 32'h8000_0004, '0, 0, '0, '0, g, w, acc);
    exp_q.push_back(mem_word(32'h8000_0004, 1'b0, 32'h0));
    wait_rsp(20, g, w, d, e, at, both);
    n_cmp++; if (g !== 1'b1 || d !== exp_q.pop_front() || at - acc !== 3) begin n_err++; $display("FAIL tmo_next_txn: got g%b d%h lat%0d want g1 lat3", g, d, at - acc); end
  endtask

  task automatic test_timeout_req();
    bit g, w, both; int acc, at; logic [31:0] d; logic e;
    req_stall = 100000;
    issue(1, 0, 32'h8000_0040, '0, 0, '0, '0, g, w, acc);
    wait_rsp(TIMEOUT + 20, g, w, d, e, at, both);
    n_cmp++; if (g !== 1'b1 || w !== 1'b0 || at - acc !== TIMEOUT + 1 || e !== 1'b1 || d !== 32'h0)
      begin n_err++; $display("FAIL reqtmo_rsp: got g%b lsu%b lat%0d e%b d%h want g1 lsu0 lat%0d e1 d0", g, w, at - acc, e, d, TIMEOUT + 1); end
    @(negedge clk);
    n_cmp++; if ({busy, lsu_req_ready, mem_rsp_ready, mem_req_valid} !== 4'b0100) begin n_err++; $display("FAIL reqtmo_no_orphan: got %b want 0100", {busy, lsu_req_ready, mem_rsp_ready, mem_req_valid}); end
    req_stall = 0;
  endtask

  task automatic test_stray();
    bit seen;
    stray = 1; seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (ifu_rsp_valid || lsu_rsp_valid || busy || mem_rsp_ready) seen = 1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL stray_ignored: got reaction %b want 0", seen); end
    stray = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit g, w, both, kind, er; int acc, at, prev_at, rs, ws, lat;
    logic [31:0] a, wd, d, ex; logic we, e; logic [3:0] wm;
    prev_at = 0;
    for (int n = 0; n < 24; n++) begin
      kind = 1'($urandom_range(0, 1)); a = $urandom; wd = $urandom;
      we = 1'($urandom_range(0, 1)); wm = 4'($urandom_range(0, 15));
      rs = int'($urandom_range(0, 3)); ws = int'($urandom_range(0, 3)); er = 1'($urandom_range(0, 1));
      req_stall = rs; rsp_stall = ws; cfg_err = er;
      issue(!kind, kind, a, a, we, wd, wm, g, w, acc);
      n_cmp++; if (g !== 1'b1 || w !== kind) begin n_err++; $display("FAIL b2b_grant[%0d]: got g%b lsu%b want g1 lsu%b", n, g, w, kind); end
      n_cmp++; if (mem_req_addr !== a || mem_req_wen !== (kind ? we : 1'b0) || mem_req_wmask !== (kind ? wm : 4'h0))
        begin n_err++; $display("FAIL b2b_memreq[%0d]: got a%h w%b m%h want a%h w%b m%h", n, mem_req_addr, mem_req_wen, mem_req_wmask, a, kind ? we : 1'b0, kind ? wm : 4'h0); end
      if (kind) begin
        n_cmp++; if (mem_req_wdata !== wd) begin n_err++; $display("FAIL b2b_wdata[%0d]: got %h want %h", n, mem_req_wdata, wd); end
      end
      if (n > 0) begin
        n_cmp++; if (acc - prev_at !== 1) begin n_err++; $display("FAIL b2b_gap[%0d]: got %0d want 1", n, acc - prev_at); end
      end
      exp_q.push_back(kind ? mem_word(a, we, wd) : mem_word(a, 1'b0, 32'h0));
      lat = 3 + rs + ws;
      wait_rsp(30, g, w, d, e, at, both);
      ex = exp_q.pop_front();
      n_cmp++; if (g !== 1'b1 || w !== kind || both !== 1'b0 || at - acc !== lat)
        begin n_err++; $display("FAIL b2b_rsp[%0d]: got g%b lsu%b both%b lat%0d want g1 lsu%b both0 lat%0d", n, g, w, both, at - acc, kind, lat); end
      n_cmp++; if (d !== ex || e !== er) begin n_err++; $display("FAIL b2b_data[%0d]: got d%h e%b want d%h e%b", n, d, e, ex, er); end
      prev_at = at;
    end
    req_stall = 0; rsp_stall = 0; cfg_err = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit g, w, in_wait, seen; int acc;
    silent = 1; in_wait = 0;
    issue(0, 1, '0, 32'h8000_3000, 1'b0, '0, '0, g, w, acc);
    for (int i = 0; i < 10 && !in_wait; i++) begin
      if (mem_rsp_ready) in_wait = 1; else @(negedge clk);
    end
    n_cmp++; if (in_wait !== 1'b1) begin n_err++; $display("FAIL rstmid_reach_wait: got %b want 1", in_wait); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid, busy} !== 5'b0 || dbg_state !== ST_IDLE)
      begin n_err++; $display("FAIL rstmid_async: got %b st%0d want 00000 st0", {mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid, busy}, dbg_state); end
    @(negedge clk);
    rst = 1'b0; silent = 0;
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got st%0d busy%b want st0 busy0", dbg_state, busy); end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ifu_rsp_valid || lsu_rsp_valid || busy) seen = 1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_rsp: got activity %b want 0", seen); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_ifu_fetch();
    test_priority();
    test_stall_err();
    test_timeout_wait();
    test_timeout_req();
    test_stray();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_23060191_mem_arbiter.md
# ysyx_23060191_mem_arbiter

Two-requester arbiter that shares the single core memory port between the IFU (instruction fetch) and the LSU (load/store). It accepts one request at a time, registers it, drives it onto the memory port, and returns the registered response to the owning requester. It also enforces a response timeout and drains orphaned responses. It sits between IFU/LSU and the memory slave; one transaction is outstanding at most.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, maximum cycles spent in REQ+WAIT before an error response (counter width `$clog2(TIMEOUT+1)`)

- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ifu_req_valid` / `ifu_req_ready`  in/out  1  IFU request handshake (read only)
- `ifu_req_addr`  in  ADDR_W  fetch address
- `ifu_rsp_valid`  out  1  one-cycle response pulse to IFU
- `ifu_rsp_data`  out  DATA_W  fetched instruction
- `ifu_rsp_err`  out  1  timeout/bus error
- `lsu_req_valid` / `lsu_req_ready`  in/out  1  LSU request handshake
- `lsu_req_addr`  in  ADDR_W; `lsu_req_wen` in 1; `lsu_req_wdata` in DATA_W; `lsu_req_wmask` in DATA_W/8
- `lsu_rsp_valid`  out  1; `lsu_rsp_rdata`  out  DATA_W; `lsu_rsp_err`  out  1
- `mem_req_valid` / `mem_req_ready`  out/in  1  memory request handshake
- `mem_req_addr`, `mem_req_wen`, `mem_req_wdata`, `mem_req_wmask`  out  as LSU fields
- `mem_rsp_valid` / `mem_rsp_ready`  in/out  1  memory response handshake
- `mem_rsp_data`  in  DATA_W; `mem_rsp_err`  in  1
- `busy`  out  1  high in any state other than IDLE, or while an orphan is pending

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Owner register: 0 = IFU, 1 = LSU.
- IDLE: `lsu_req_ready = 1` when no orphan is pending. `ifu_req_ready = 1` when no orphan is pending and `!lsu_req_valid`. Fixed priority: LSU wins a simultaneous request.
- On an accepted handshake, the block latches addr/wen/wdata/wmask and the owner, clears the timeout counter, and moves to REQ. IFU requests latch `wen = 0`, `wmask = 0`.
- REQ: `mem_req_valid = 1` with the latched fields. When `mem_req_ready` is seen, the FSM moves to WAIT.
- WAIT: `mem_rsp_ready = 1`. When `mem_rsp_valid` is seen, the block latches data and err and moves to RESP.
- RESP: the owner's `*_rsp_valid` is high for exactly one cycle with the latched data/err. The other requester's rsp_valid stays 0. The FSM then returns to IDLE. Requesters have no response backpressure.
- Timeout: the counter increments every cycle in REQ and WAIT. When the counter reaches `TIMEOUT`, the FSM goes to RESP with err = 1 and data = 0. If this happens in REQ, `mem_req_valid` drops and no orphan is created. If it happens in WAIT, the orphan bit is set.
- Orphan drain: while the orphan bit is set, IDLE holds both `req_ready` low and drives `mem_rsp_ready = 1`. The first `mem_rsp_valid` clears the orphan bit, and its data is discarded.
- Stray `mem_rsp_valid` in IDLE with no orphan pending: ignored, `mem_rsp_ready = 0`.
- Request fields are don't-care outside the accepting cycle.

## Timing
- Reset: state = IDLE, owner = 0, orphan = 0, counter = 0, latched regs = 0. All valid and ready outputs are 0 except the IDLE-derived `*_req_ready`. `busy = 0`.
- Reset mid-transaction takes effect immediately, with no response to the requester. The memory slave shares `rst`, so it also abandons the transaction.
- With zero-wait memory (ready and rsp_valid both immediate): accept at cycle t, REQ at t+1, WAIT at t+2, RESP pulse at t+3, IDLE at t+4. The next accept is possible at t+4, so throughput is 1 transaction per 4 cycles.
- Response latency is 3 cycles plus memory stall cycles, measured from the accept cycle.
- All outputs are derived from registered state and latched fields. The only combinational input dependency is `ifu_req_ready` on `lsu_req_valid`.

## Structure
- Shared package/defines: FSM state encoding, owner encoding, `CPU_WIDTH`-derived width constants, default `TIMEOUT`.
- Single module with no sub-module. The timeout counter is inline. A generic fixed-priority grant helper is not warranted for two requesters.

## Test plan
- LSU and IFU both request in the same IDLE cycle (LSU store addr 0x8000_0010, wdata 0xDEAD_BEEF, wmask 0xF) -> LSU is granted, and the memory sees wen = 1 with those fields. The IFU is granted on the next IDLE with `ifu_rsp_data` = mem data.
- IFU fetch of 0x8000_0000 with zero-wait memory returning 0x0000_0413 -> `ifu_rsp_valid` pulses at accept+3 with data 0x0000_0413 and err = 0. `lsu_rsp_valid` stays 0.
- Memory holds `mem_req_ready` low for 5 cycles, then returns rsp_err = 1 -> the LSU gets an rsp pulse at accept+8 with err = 1.
- `mem_rsp_valid` is never asserted and `TIMEOUT` = 255 -> the owner gets err = 1, data = 0 after 255 cycles. Both `req_ready` stay low until a late `mem_rsp_valid`, after which IDLE accepts again and the late data is not forwarded.
- `rst` is pulsed while in WAIT -> all valids drop asynchronously, no rsp pulse follows, and the FSM is in IDLE with `busy = 0` on the first cycle after reset deasserts.
